// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcode values,
// FSM state encoding, datapath mux/ALU encodings, trap causes and the
// bundle of datapath strobes produced by the state decoder.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] TRAP_NONE        = 2'b00;
    localparam logic [1:0] TRAP_ILLEGAL     = 2'b01;
    localparam logic [1:0] TRAP_MEM_TIMEOUT = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_EXEC,
        S_RWB,
        S_BRANCH,
        S_JUMP,
        S_JAL,
        S_ADDI_EX,
        S_ADDI_WB,
        S_TRAP
    } state_t;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       pc_write_cond;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       reg_dst;
        logic       reg_write;
        logic       mem_to_reg;
        logic       jal;
        logic       retire;
        logic       trap;
    } ctrl_t;

    // States that wait on the memory handshake and are covered by the timeout.
    function automatic logic is_mem_state(input state_t s);
        return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// State -> datapath strobe decode for the multi-cycle controller.
// Purely combinational. Every strobe is a function of the current state,
// except the FETCH write-back strobes and the MEMWR retire, which also
// follow mem_ready so they fire on the cycle the access completes.
// Ports:
//   state      in   current FSM state
//   mem_ready  in   memory access complete this cycle
//   ctrl       out  strobe bundle (all zero unless set by the state)
import mips_pkg::*;

module multicycle_ctrl_decode (
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_read  = 1'b1;
                ctrl.iord      = 1'b0;
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_op    = ALUOP_ADD;
                if (mem_ready) begin
                    ctrl.ir_write  = 1'b1;
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCSRC_ALU;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed here so BRANCH can take it from ALUOut.
                ctrl.alu_src_a = 1'b0;
                ctrl.alu_src_b = SRCB_IMM_SH;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_req  = 1'b1;
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b1;
                ctrl.retire     = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_req   = 1'b1;
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
                ctrl.retire    = mem_ready;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_RWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.alu_src_b     = SRCB_RT;
                ctrl.alu_op        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.retire        = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.retire    = 1'b1;
            end
            S_JAL: begin
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.reg_write = 1'b1;
                ctrl.jal       = 1'b1;
                ctrl.retire    = 1'b1;
            end
            S_ADDI_EX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_ADDI_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b0;
                ctrl.mem_to_reg = 1'b0;
                ctrl.retire     = 1'b1;
            end
            S_TRAP: begin
                ctrl.trap = 1'b1;
            end
            default: begin
                ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for a single-ALU MIPS datapath with shared memory.
// Steps one instruction at a time through a Moore FSM, handshakes with a
// variable-latency memory, counts retired instructions and halts in TRAP
// on an illegal opcode or a memory access that never completes.
//
// Ports:
//   clk, rst_n              clock, async active-low reset
//   run                     fetch/execute enable, honoured at instruction boundaries
//   opcode                  IR[31:26], used in DECODE only
//   zero                    ALU zero flag for beq
//   mem_ready / mem_req     memory handshake
//   IorD .. jal             datapath strobes
//   retire, instr_count     retirement pulse and wrapping count
//   trap, trap_cause        sticky halt and its reason
//
// state     | meaning
// ----------+------------------------------------------------
// IDLE      | no instruction in flight, waiting for run
// FETCH     | read instruction at PC, PC <= PC+4 on mem_ready
// DECODE    | dispatch on opcode, precompute branch target
// MEMADR    | lw/sw effective address
// MEMRD     | lw data read
// MEMWB     | lw register write-back (final)
// MEMWR     | sw data write (final on mem_ready)
// EXEC      | R-type ALU operation
// RWB       | R-type write-back (final)
// BRANCH    | beq compare and conditional PC load (final)
// JUMP      | j PC load (final)
// JAL       | jal PC load and link to $31 (final)
// ADDI_EX   | addi ALU operation
// ADDI_WB   | addi write-back (final)
// TRAP      | halted until reset
import mips_pkg::*;

module multicycle_ctrl #(
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             pc_en,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             RegDst,
    output logic             RegWrite,
    output logic             MemtoReg,
    output logic             jal,
    output logic             retire,
    output logic [CNT_W-1:0] instr_count,
    output logic             trap,
    output logic [1:0]       trap_cause
);

    localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);
    localparam int WAIT_W     = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    // Down-counter reload: terminal count 0 is reached on the MEM_TIMEOUT-th wait cycle.
    localparam logic [WAIT_W-1:0] WAIT_LOAD =
        TIMEOUT_EN ? WAIT_W'(MEM_TIMEOUT - 1) : '0;

    state_t            state;
    state_t            state_next;
    ctrl_t             ctrl;
    logic              is_lw_q;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        trap_cause_q;
    logic              wait_expired;
    state_t            after_final;

    multicycle_ctrl_decode u_decode (
        .state     (state),
        .mem_ready (mem_ready),
        .ctrl      (ctrl)
    );

    assign wait_expired = TIMEOUT_EN && is_mem_state(state) && !mem_ready
                          && (wait_cnt == '0);
    assign after_final  = run ? S_FETCH : S_IDLE;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (run) state_next = S_FETCH;
            end
            S_FETCH: begin
                if (mem_ready)         state_next = S_DECODE;
                else if (wait_expired) state_next = S_TRAP;
            end
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_RTYPE:     state_next = S_EXEC;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
                    OP_JAL:       state_next = S_JAL;
                    OP_ADDI:      state_next = S_ADDI_EX;
                    default:      state_next = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                // opcode may have moved on; use the lw/sw choice latched in DECODE.
                state_next = is_lw_q ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                if (mem_ready)         state_next = S_MEMWB;
                else if (wait_expired) state_next = S_TRAP;
            end
            S_MEMWR: begin
                if (mem_ready)         state_next = after_final;
                else if (wait_expired) state_next = S_TRAP;
            end
            S_EXEC:    state_next = S_RWB;
            S_ADDI_EX: state_next = S_ADDI_WB;
            S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_JAL, S_ADDI_WB: begin
                state_next = after_final;
            end
            S_TRAP:    state_next = S_TRAP;
            default:   state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            is_lw_q      <= 1'b0;
            wait_cnt     <= WAIT_LOAD;
            instr_count  <= '0;
            trap_cause_q <= TRAP_NONE;
        end else begin
            state <= state_next;
            if (state == S_DECODE) begin
                is_lw_q <= (opcode == OP_LW);
            end
            // Every mem state is entered from a different state, so any
            // state change rearms the timer for the access that follows.
            if (state_next != state) begin
                wait_cnt <= WAIT_LOAD;
            end else if (wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (ctrl.retire) begin
                instr_count <= instr_count + CNT_W'(1);
            end
            if ((state_next == S_TRAP) && (state != S_TRAP)) begin
                trap_cause_q <= (state == S_DECODE) ? TRAP_ILLEGAL : TRAP_MEM_TIMEOUT;
            end
        end
    end

    assign mem_req    = ctrl.mem_req;
    assign IorD       = ctrl.iord;
    assign MemRead    = ctrl.mem_read;
    assign MemWrite   = ctrl.mem_write;
    assign IRWrite    = ctrl.ir_write;
    assign pc_en      = ctrl.pc_write | (ctrl.pc_write_cond & zero);
    assign PCSource   = ctrl.pc_source;
    assign ALUOp      = ctrl.alu_op;
    assign ALUSrcA    = ctrl.alu_src_a;
    assign ALUSrcB    = ctrl.alu_src_b;
    assign RegDst     = ctrl.reg_dst;
    assign RegWrite   = ctrl.reg_write;
    assign MemtoReg   = ctrl.mem_to_reg;
    assign jal        = ctrl.jal;
    assign retire     = ctrl.retire;
    assign trap       = ctrl.trap;
    assign trap_cause = trap_cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

    localparam int CNT_W = 4;
    localparam int MEM_TIMEOUT = 16;

    localparam logic [5:0] C_R    = 6'b000000;
    localparam logic [5:0] C_LW   = 6'b100011;
    localparam logic [5:0] C_SW   = 6'b101011;
    localparam logic [5:0] C_BEQ  = 6'b000100;
    localparam logic [5:0] C_J    = 6'b000010;
    localparam logic [5:0] C_JAL  = 6'b000011;
    localparam logic [5:0] C_ADDI = 6'b001000;

    logic clk = 1'b0;
    logic rst_n, run, zero, mem_ready;
    logic [5:0] opcode;
    logic mem_req, IorD, MemRead, MemWrite, IRWrite, pc_en;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic ALUSrcA, RegDst, RegWrite, MemtoReg, jal, retire, trap;
    logic [CNT_W-1:0] instr_count;
    logic [1:0] trap_cause;

    int n_checks = 0;
    int n_pass = 0;

    typedef struct {
        int lat;
        int req;
        int mw;
        int rw;
        int pc;
        int jl;
    } exp_t;

    multicycle_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .pc_en(pc_en), .PCSource(PCSource),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegDst(RegDst),
        .RegWrite(RegWrite), .MemtoReg(MemtoReg), .jal(jal), .retire(retire),
        .instr_count(instr_count), .trap(trap), .trap_cause(trap_cause)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [19:0] obs();
        return {mem_req, IorD, MemRead, MemWrite, IRWrite, pc_en, PCSource, ALUOp,
                ALUSrcA, ALUSrcB, RegDst, RegWrite, MemtoReg, jal, retire, trap};
    endfunction

    function automatic logic [19:0] mk(input logic req, input logic iord, input logic mr,
                                       input logic mw, input logic irw, input logic pce,
                                       input logic [1:0] pcs, input logic [1:0] aop,
                                       input logic sa, input logic [1:0] sb,
                                       input logic rd, input logic rw, input logic m2r,
                                       input logic jl, input logic ret, input logic tr);
        return {req, iord, mr, mw, irw, pce, pcs, aop, sa, sb, rd, rw, m2r, jl, ret, tr};
    endfunction

    // Instruction-level expectations: cycle count and how many cycles each
    // strobe is seen, given fetch wait fw and data wait dw.
    function automatic exp_t model(input logic [5:0] op, input int fw, input int dw,
                                   input logic zv);
        exp_t m;
        m.req = 1 + fw;
        m.pc = 1;
        m.mw = 0;
        m.rw = 0;
        m.jl = 0;
        m.lat = 0;
        case (op)
            C_LW: begin m.lat = 5 + fw + dw; m.req += 1 + dw; m.rw = 1; end
            C_SW: begin m.lat = 4 + fw + dw; m.req += 1 + dw; m.mw = 1 + dw; end
            C_R, C_ADDI: begin m.lat = 4 + fw; m.rw = 1; end
            C_BEQ: begin m.lat = 3 + fw; m.pc += zv ? 1 : 0; end
            C_J: begin m.lat = 3 + fw; m.pc += 1; end
            C_JAL: begin m.lat = 3 + fw; m.pc += 1; m.rw = 1; m.jl = 1; end
            default: m.lat = -1;
        endcase
        return m;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        run = 1'b0;
        mem_ready = 1'b0;
        opcode = 6'd0;
        zero = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Runs one instruction starting from a FETCH cycle; memory responds after
    // fw/dw wait cycles, mem_ready is random whenever no request is up and
    // opcode is random except in the decode cycle.
    task automatic exec_instr(input logic [5:0] op, input int fw, input int dw, input logic zv,
                              output int lat, output int n_req, output int n_mw,
                              output int n_rw, output int n_pc, output int n_jal,
                              output logic done);
        int acc;
        int wcnt;
        logic dec_next;
        logic nd;
        lat = 0; n_req = 0; n_mw = 0; n_rw = 0; n_pc = 0; n_jal = 0;
        done = 1'b0; acc = 0; wcnt = 0; dec_next = 1'b0;
        zero = zv;
        for (int c = 0; c < 60 && !done; c++) begin
            @(negedge clk);
            if (mem_req) mem_ready = (wcnt == ((acc == 0) ? fw : dw));
            else mem_ready = 1'($urandom_range(0, 1));
            opcode = dec_next ? op : 6'($urandom);
            #1;
            lat++;
            if (mem_req) n_req++;
            if (MemWrite) n_mw++;
            if (RegWrite) n_rw++;
            if (pc_en) n_pc++;
            if (jal) n_jal++;
            nd = 1'b0;
            if (mem_req) begin
                if (mem_ready) begin
                    if (acc == 0) nd = 1'b1;
                    acc++;
                    wcnt = 0;
                end else begin
                    wcnt++;
                end
            end
            dec_next = nd;
            if (retire) done = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        run = 1'b1;
        mem_ready = 1'b1;
        opcode = C_LW;
        zero = 1'b1;
        #3;
        n_checks++;
        if (obs() !== 20'h0) $display("FAIL reset_outputs got %h expected 0", obs());
        else n_pass++;
        n_checks++;
        if (instr_count !== '0) $display("FAIL reset_count got %0d expected 0", instr_count);
        else n_pass++;
        n_checks++;
        if (trap_cause !== 2'b00) $display("FAIL reset_cause got %b expected 00", trap_cause);
        else n_pass++;
    endtask

    task automatic test_lw_trace();
        logic [19:0] ev [5];
        ev[0] = mk(1,0,1,0,1,1,2'b00,2'b00,0,2'b01,0,0,0,0,0,0);
        ev[1] = mk(0,0,0,0,0,0,2'b00,2'b00,0,2'b11,0,0,0,0,0,0);
        ev[2] = mk(0,0,0,0,0,0,2'b00,2'b00,1,2'b10,0,0,0,0,0,0);
        ev[3] = mk(1,1,1,0,0,0,2'b00,2'b00,0,2'b00,0,0,0,0,0,0);
        ev[4] = mk(0,0,0,0,0,0,2'b00,2'b00,0,2'b00,0,1,1,0,1,0);
        do_reset();
        run = 1'b1; mem_ready = 1'b1; opcode = C_LW;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 1) run = 1'b0;
            #1;
            n_checks++;
            if (obs() !== ev[i]) $display("FAIL lw_cycle%0d got %h expected %h", i + 1, obs(), ev[i]);
            else n_pass++;
        end
        @(negedge clk); #1;
        n_checks++;
        if (obs() !== 20'h0) $display("FAIL lw_idle got %h expected 0", obs());
        else n_pass++;
        n_checks++;
        if (instr_count !== CNT_W'(1)) $display("FAIL lw_count got %0d expected 1", instr_count);
        else n_pass++;
    endtask

    task automatic test_sw_wait();
        do_reset();
        run = 1'b1; mem_ready = 1'b1; opcode = C_SW;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 1) run = 1'b0;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_ready = (k == 3);
            #1;
            n_checks++;
            if ({mem_req, MemWrite, IorD, MemRead} !== 4'b1110)
                $display("FAIL sw_strobes_c%0d got %b expected 1110", k, {mem_req, MemWrite, IorD, MemRead});
            else n_pass++;
            n_checks++;
            if (retire !== (k == 3)) $display("FAIL sw_retire_c%0d got %b expected %b", k, retire, k == 3);
            else n_pass++;
        end
        @(negedge clk); mem_ready = 1'b0; #1;
        n_checks++;
        if (obs() !== 20'h0) $display("FAIL sw_idle got %h expected 0", obs());
        else n_pass++;
        n_checks++;
        if (instr_count !== CNT_W'(1)) $display("FAIL sw_count got %0d expected 1", instr_count);
        else n_pass++;
    endtask

    task automatic test_beq();
        do_reset();
        run = 1'b1; mem_ready = 1'b1; opcode = C_BEQ; zero = 1'b1;
        @(negedge clk); @(negedge clk);
        @(negedge clk); #1;
        n_checks++;
        if ({pc_en, PCSource, ALUOp, retire} !== 6'b101011)
            $display("FAIL beq_taken got %b expected 101011", {pc_en, PCSource, ALUOp, retire});
        else n_pass++;
        @(negedge clk); zero = 1'b0;
        @(negedge clk); run = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if ({pc_en, PCSource, retire} !== 4'b0011)
            $display("FAIL beq_not_taken got %b expected 0011", {pc_en, PCSource, retire});
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (instr_count !== CNT_W'(2)) $display("FAIL beq_count got %0d expected 2", instr_count);
        else n_pass++;
    endtask

    task automatic test_jal();
        int early;
        early = 0;
        do_reset();
        run = 1'b1; mem_ready = 1'b1; opcode = C_JAL; zero = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (i == 1) run = 1'b0;
            #1;
            if (retire) early++;
        end
        @(negedge clk); #1;
        n_checks++;
        if (early != 0) $display("FAIL jal_early_retire got %0d expected 0", early);
        else n_pass++;
        n_checks++;
        if ({pc_en, RegWrite, jal, PCSource, retire} !== 6'b111101)
            $display("FAIL jal_cycle got %b expected 111101", {pc_en, RegWrite, jal, PCSource, retire});
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if (obs() !== 20'h0 || instr_count !== CNT_W'(1))
            $display("FAIL jal_after got %h/%0d expected 0/1", obs(), instr_count);
        else n_pass++;
    endtask

    task automatic test_run_drop_exec();
        do_reset();
        run = 1'b1; mem_ready = 1'b1; opcode = C_R;
        @(negedge clk); @(negedge clk);
        @(negedge clk); run = 1'b0; #1;
        n_checks++;
        if ({ALUSrcA, ALUSrcB, ALUOp, retire} !== 6'b100100)
            $display("FAIL exec_cycle got %b expected 100100", {ALUSrcA, ALUSrcB, ALUOp, retire});
        else n_pass++;
        @(negedge clk); #1;
        n_checks++;
        if ({RegWrite, RegDst, MemtoReg, retire} !== 4'b1101)
            $display("FAIL rwb_cycle got %b expected 1101", {RegWrite, RegDst, MemtoReg, retire});
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            n_checks++;
            if (obs() !== 20'h0) $display("FAIL run_drop_idle%0d got %h expected 0", i, obs());
            else n_pass++;
        end
        n_checks++;
        if (instr_count !== CNT_W'(1)) $display("FAIL run_drop_count got %0d expected 1", instr_count);
        else n_pass++;
    endtask

    task automatic test_illegal();
        do_reset();
        run = 1'b1; mem_ready = 1'b1; opcode = 6'b111111;
        @(negedge clk); @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            opcode = 6'($urandom);
            #1;
            n_checks++;
            if (obs() !== 20'h1 || trap_cause !== 2'b01)
                $display("FAIL illegal_trap%0d got %h/%b expected 00001/01", i, obs(), trap_cause);
            else n_pass++;
        end
        n_checks++;
        if (instr_count !== '0) $display("FAIL illegal_count got %0d expected 0", instr_count);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int nreq;
        logic seen;
        nreq = 0;
        seen = 1'b0;
        do_reset();
        run = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk); #1;
            if (trap) seen = 1'b1;
            else if (mem_req) nreq++;
        end
        n_checks++;
        if (!seen) $display("FAIL timeout_reached got 0 expected 1");
        else n_pass++;
        n_checks++;
        if (nreq != MEM_TIMEOUT) $display("FAIL timeout_wait_cycles got %0d expected %0d", nreq, MEM_TIMEOUT);
        else n_pass++;
        n_checks++;
        if (trap_cause !== 2'b10 || obs() !== 20'h1)
            $display("FAIL timeout_state got %b/%h expected 10/00001", trap_cause, obs());
        else n_pass++;
    endtask

    task automatic test_reset_in_memwr();
        do_reset();
        run = 1'b1; mem_ready = 1'b1; opcode = C_J;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 3) opcode = C_SW;
        end
        @(negedge clk); mem_ready = 1'b0; #1;
        n_checks++;
        if ({MemWrite, instr_count} !== {1'b1, CNT_W'(1)})
            $display("FAIL memwr_before_reset got %b/%0d expected 1/1", MemWrite, instr_count);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs() !== 20'h0 || instr_count !== '0)
            $display("FAIL async_reset got %h/%0d expected 0/0", obs(), instr_count);
        else n_pass++;
        mem_ready = 1'b1;
        @(negedge clk); #1;
        n_checks++;
        if (MemWrite !== 1'b0) $display("FAIL reset_write_dropped got %b expected 0", MemWrite);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [5:0] tab [7];
        int count_model;
        int lat, nr, nmw, nrw, npc, njl;
        logic done;
        exp_t e;
        tab[0] = C_R; tab[1] = C_LW; tab[2] = C_SW; tab[3] = C_BEQ;
        tab[4] = C_J; tab[5] = C_JAL; tab[6] = C_ADDI;
        count_model = 0;
        do_reset();
        run = 1'b1;
        for (int n = 0; n < 40; n++) begin
            logic [5:0] op;
            int fw, dw;
            logic zv;
            op = tab[$urandom_range(0, 6)];
            fw = $urandom_range(0, 3);
            dw = $urandom_range(0, 4);
            zv = 1'($urandom_range(0, 1));
            e = model(op, fw, dw, zv);
            exec_instr(op, fw, dw, zv, lat, nr, nmw, nrw, npc, njl, done);
            n_checks++;
            if (!done) $display("FAIL rnd%0d_retired op=%b got 0 expected 1", n, op);
            else n_pass++;
            n_checks++;
            if (lat != e.lat) $display("FAIL rnd%0d_latency op=%b got %0d expected %0d", n, op, lat, e.lat);
            else n_pass++;
            n_checks++;
            if (nr != e.req) $display("FAIL rnd%0d_mem_req op=%b got %0d expected %0d", n, op, nr, e.req);
            else n_pass++;
            n_checks++;
            if (nmw != e.mw) $display("FAIL rnd%0d_memwrite op=%b got %0d expected %0d", n, op, nmw, e.mw);
            else n_pass++;
            n_checks++;
            if (nrw != e.rw) $display("FAIL rnd%0d_regwrite op=%b got %0d expected %0d", n, op, nrw, e.rw);
            else n_pass++;
            n_checks++;
            if (npc != e.pc) $display("FAIL rnd%0d_pc_en op=%b got %0d expected %0d", n, op, npc, e.pc);
            else n_pass++;
            n_checks++;
            if (njl != e.jl) $display("FAIL rnd%0d_jal op=%b got %0d expected %0d", n, op, njl, e.jl);
            else n_pass++;
            count_model = (count_model + 1) % (1 << CNT_W);
            @(posedge clk); #1;
            n_checks++;
            if (instr_count !== CNT_W'(count_model))
                $display("FAIL rnd%0d_count got %0d expected %0d", n, instr_count, count_model);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_lw_trace();
        test_sw_wait();
        test_beq();
        test_jal();
        test_run_drop_exec();
        test_illegal();
        test_timeout();
        test_reset_in_memwr();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
